// File: rtl/command_dispatcher.sv
// Buffers {address, command} requests in a FIFO and replays them onto the shared object-bank bus
// as single-cycle strobes separated by a programmable idle gap. Address 0 is the bus-idle code.
module command_dispatcher #(
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int ADDR_W     = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [ADDR_W-1:0]        in_addr_i,
  input  logic                     in_cmd_i,
  output logic [ADDR_W-1:0]        address_o,
  output logic                     command_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     busy_o,
  output logic                     drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic [ADDR_W:0]    mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   count_q;
  logic [ADDR_W:0]    hold_p0;
  logic               vld_p0;

  logic               full, empty, accept, push, pop;

  assign full       = (count_q == LVL_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign in_ready_o = !full;
  assign accept     = in_valid_i && !full;
  assign push       = accept && (in_addr_i != '0);
  assign pop        = (state_q == ST_IDLE) && !empty;

  assign level_o    = count_q;
  assign busy_o     = !empty || (state_q != ST_IDLE);
  assign vld_p0     = (state_q == ST_ISSUE);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= {in_cmd_i, in_addr_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_o   <= 1'b0;
    end else begin
      drop_o <= accept && (in_addr_i == '0);
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + LVL_W'(1);
        2'b01:   count_q <= count_q - LVL_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // stage p0: head captured at pop, presented on the bus during the following ISSUE cycle
  always_ff @(posedge clk_i) begin
    if (pop) begin
      hold_p0 <= mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (GAP_CYCLES > 0) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gap_cnt_d = '0;
      end
    endcase
  end

  // stage p1: bus register, reset asynchronously so the bus idles the instant reset asserts
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      address_o <= '0;
      command_o <= 1'b0;
    end else if (vld_p0) begin
      address_o <= hold_p0[ADDR_W-1:0];
      command_o <= hold_p0[ADDR_W];
    end else begin
      address_o <= '0;
      command_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_command_dispatcher.sv
// Directed bench for command_dispatcher: a GAP_CYCLES=1 instance (g1) and a GAP_CYCLES=0 instance (g0).
module tb_command_dispatcher;

  localparam int AW = 5;
  localparam int LW = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          g1_valid, g1_ready, g1_cmd, g1_cmd_o, g1_busy, g1_drop;
  logic [AW-1:0] g1_addr, g1_addr_o;
  logic [LW-1:0] g1_level;
  logic          g0_valid, g0_ready, g0_cmd, g0_cmd_o, g0_busy, g0_drop;
  logic [AW-1:0] g0_addr, g0_addr_o;
  logic [LW-1:0] g0_level;

  command_dispatcher #(.DEPTH(4), .GAP_CYCLES(1), .ADDR_W(AW)) dut_g1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(g1_valid), .in_ready_o(g1_ready), .in_addr_i(g1_addr), .in_cmd_i(g1_cmd),
    .address_o(g1_addr_o), .command_o(g1_cmd_o), .level_o(g1_level),
    .busy_o(g1_busy), .drop_o(g1_drop)
  );

  command_dispatcher #(.DEPTH(4), .GAP_CYCLES(0), .ADDR_W(AW)) dut_g0 (
    .clk_i(clk), .rst_n_i(rst_n),
    .in_valid_i(g0_valid), .in_ready_o(g0_ready), .in_addr_i(g0_addr), .in_cmd_i(g0_cmd),
    .address_o(g0_addr_o), .command_o(g0_cmd_o), .level_o(g0_level),
    .busy_o(g0_busy), .drop_o(g0_drop)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int valid, addr, cmd;
    int rdy, lvl, ao, co, busy, drop;
  } vec_t;

  vec_t tbl[15];

  task automatic add_vec(input int i, input int valid, input int addr, input int cmd,
                         input int rdy, input int lvl, input int ao, input int co,
                         input int busy, input int drop);
    tbl[i] = '{valid, addr, cmd, rdy, lvl, ao, co, busy, drop};
  endtask

  logic [AW:0] exp_q[$];
  logic [AW:0] exp_e;

  int ba[8] = '{3, 7, 12, 1, 31, 18, 9, 22};
  int bc[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
  int seq_a[8] = '{0, 0, 9, 0, 17, 0, 30, 0};
  int seq_c[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
  int got_a[8];
  int got_c[8];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, issued, last, stalls, saw_full, p;

    rst_n = 1'b0;
    g1_valid = 1'b0; g1_addr = '0; g1_cmd = 1'b0;
    g0_valid = 1'b0; g0_addr = '0; g0_cmd = 1'b0;
    #1;
    check("reset_addr", g1_addr_o, 0);
    check("reset_cmd", g1_cmd_o, 0);
    check("reset_level", g1_level, 0);
    check("reset_ready", g1_ready, 1);
    check("reset_busy", g1_busy, 0);
    check("reset_drop", g1_drop, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // single push, drop of address 0, then push/pop overlap
    add_vec(0,  1,  5, 1,  1, 1,  0, 0, 1, 0);
    add_vec(1,  0,  0, 0,  1, 0,  0, 0, 1, 0);
    add_vec(2,  0,  0, 0,  1, 0,  5, 1, 1, 0);
    add_vec(3,  0,  0, 0,  1, 0,  0, 0, 0, 0);
    add_vec(4,  0,  0, 0,  1, 0,  0, 0, 0, 0);
    add_vec(5,  1,  0, 1,  1, 0,  0, 0, 0, 1);
    add_vec(6,  0,  0, 0,  1, 0,  0, 0, 0, 0);
    add_vec(7,  0,  0, 0,  1, 0,  0, 0, 0, 0);
    add_vec(8,  1, 20, 0,  1, 1,  0, 0, 1, 0);
    add_vec(9,  1,  2, 1,  1, 1,  0, 0, 1, 0);
    add_vec(10, 0,  0, 0,  1, 1, 20, 0, 1, 0);
    add_vec(11, 0,  0, 0,  1, 1,  0, 0, 1, 0);
    add_vec(12, 0,  0, 0,  1, 0,  0, 0, 1, 0);
    add_vec(13, 0,  0, 0,  1, 0,  2, 1, 1, 0);
    add_vec(14, 0,  0, 0,  1, 0,  0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      g1_valid = (tbl[i].valid != 0);
      g1_addr  = AW'(tbl[i].addr);
      g1_cmd   = (tbl[i].cmd != 0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_ready", i), g1_ready, tbl[i].rdy);
      check($sformatf("vec%0d_level", i), g1_level, tbl[i].lvl);
      check($sformatf("vec%0d_addr", i), g1_addr_o, tbl[i].ao);
      check($sformatf("vec%0d_cmd", i), g1_cmd_o, tbl[i].co);
      check($sformatf("vec%0d_busy", i), g1_busy, tbl[i].busy);
      check($sformatf("vec%0d_drop", i), g1_drop, tbl[i].drop);
    end
    g1_valid = 1'b0;

    // burst of 8 with a source that holds stalled requests
    idx = 0; issued = 0; last = -1; stalls = 0; saw_full = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 80 && issued < 8; cyc++) begin
      if (idx < 8) begin
        g1_valid = 1'b1; g1_addr = AW'(ba[idx]); g1_cmd = (bc[idx] != 0);
      end else begin
        g1_valid = 1'b0;
      end
      if (g1_valid && g1_ready) begin
        exp_q.push_back({g1_cmd, g1_addr});
        idx++;
      end else if (g1_valid) begin
        stalls++;
      end
      @(posedge clk); #1;
      check("burst_ready_vs_level", g1_ready, (g1_level != 3'd4) ? 1 : 0);
      if (g1_level == 3'd4) saw_full = 1;
      if (g1_addr_o != '0) begin
        if (exp_q.size() == 0) begin
          check("burst_unexpected_addr", g1_addr_o, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check("burst_addr", g1_addr_o, exp_e[AW-1:0]);
          check("burst_cmd", g1_cmd_o, exp_e[AW]);
        end
        if (last >= 0) check("burst_spacing", cyc - last, 3);
        last = cyc;
        issued++;
      end
    end
    g1_valid = 1'b0;
    check("burst_issued", issued, 8);
    check("burst_stall_seen", (stalls > 0) ? 1 : 0, 1);
    check("burst_full_seen", saw_full, 1);
    repeat (3) @(posedge clk); #1;
    check("burst_end_busy", g1_busy, 0);
    check("burst_end_level", g1_level, 0);

    // back-to-back build: bus pattern A,0,B,0,C,0
    for (int s = 0; s < 8; s++) begin
      g0_valid = (s < 3);
      g0_addr  = (s < 3) ? AW'(seq_a[2 + 2 * s]) : '0;
      g0_cmd   = (s < 3) ? (seq_c[2 + 2 * s] != 0) : 1'b0;
      @(posedge clk); #1;
      got_a[s] = g0_addr_o;
      got_c[s] = g0_cmd_o;
    end
    g0_valid = 1'b0;
    for (int s = 0; s < 8; s++) begin
      check($sformatf("gap0_addr%0d", s), got_a[s], seq_a[s]);
      check($sformatf("gap0_cmd%0d", s), got_c[s], seq_c[s]);
    end

    // sustained push on every pop cycle: level holds at 2 across pointer wraps
    p = 0; issued = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (cyc < 3)       g0_valid = 1'b1;
      else if (cyc < 43) g0_valid = (g0_addr_o != '0);
      else               g0_valid = 1'b0;
      g0_addr = AW'((p % 31) + 1);
      g0_cmd  = ((p % 2) == 1);
      if (g0_valid && g0_ready) begin
        exp_q.push_back({g0_cmd, g0_addr});
        p++;
      end
      @(posedge clk); #1;
      if (cyc >= 2 && cyc < 43) check("sustain_level", g0_level, 2);
      if (g0_addr_o != '0) begin
        if (exp_q.size() == 0) begin
          check("sustain_unexpected_addr", g0_addr_o, 0);
        end else begin
          exp_e = exp_q.pop_front();
          check("sustain_addr", g0_addr_o, exp_e[AW-1:0]);
          check("sustain_cmd", g0_cmd_o, exp_e[AW]);
        end
        issued++;
      end
    end
    check("sustain_pushes_min", (p >= 20) ? 1 : 0, 1);
    check("sustain_issued", issued, p);
    check("sustain_drained", exp_q.size(), 0);
    check("sustain_busy", g0_busy, 0);

    // reset asserted while a strobe is on the bus with a request still queued
    g1_valid = 1'b1; g1_addr = 5'd11; g1_cmd = 1'b1;
    @(posedge clk); #1;
    g1_addr = 5'd13; g1_cmd = 1'b0;
    @(posedge clk); #1;
    g1_valid = 1'b0;
    for (int i = 0; i < 10 && g1_addr_o == '0; i++) begin
      @(posedge clk); #1;
    end
    check("prereset_addr", g1_addr_o, 11);
    check("prereset_level", g1_level, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midissue_rst_addr", g1_addr_o, 0);
    check("midissue_rst_cmd", g1_cmd_o, 0);
    check("midissue_rst_level", g1_level, 0);
    check("midissue_rst_ready", g1_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("postreset_bus_idle", g1_addr_o, 0);
    end
    check("postreset_busy", g1_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
